// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the FSM state type, a log2 helper and the default chunk width.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_CHUNK = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// chunk_adder: combinational CHUNK-bit ripple full adder.
// Ports: x, y, ci in; s (sum), co (carry out), c_msb (carry into top bit) out.
module chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, LSB chunk first.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, a, b, cin in;
// out_valid/out_ready, sum, cout, ovf out; busy high in RUN and DONE.
// Macro SEQ_ADDER_SUB_EN adds input sub (a - b when set, cin ignored).
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW =
    (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

  if (CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: bad WIDTH/CHUNK");
  end

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             carry_q, cout_q, ovf_q;
  logic [KW-1:0]    idx;
  logic             last;

  logic [CHUNK-1:0] s;
  logic             co, c_msb;

  // Subtraction folds into the add: b is inverted
  // and the carry forced high when operands latch.
`ifdef SEQ_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign last = (idx == KW'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_q[idx*CHUNK +: CHUNK]),
    .y     (b_q[idx*CHUNK +: CHUNK]),
    .ci    (carry_q),
    .s     (s),
    .co    (co),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= c_in;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[idx*CHUNK +: CHUNK] <= s;
          carry_q <= co;
          if (last) begin
            cout_q <= co;
            ovf_q  <= co ^ c_msb;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder against an arithmetic model.
// Covers directed cases, backpressure, reset mid-run and a CHUNK sweep.
module tb_seq_chunk_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp;
  int n_bad;
  logic sweep_go;
  int   sweep_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum[15:0]} for a w-bit add or subtract,
  // derived with integer arithmetic on unsigned and signed values.
  function automatic logic [17:0] ref_add(input int w,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c,
                                          input logic s);
    longint ua, ub, sa, sb, u, r, half, full;
    logic co, ov;
    logic [15:0] m;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
    ua = longint'(x);
    ub = longint'(y);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (s) begin
      u  = ua - ub;
      r  = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + longint'(c);
      r  = sa + sb + longint'(c);
      co = (u >= full);
    end
    ov = (r >= half) || (r < -half);
    m  = 16'(u & (full - 1));
    return {ov, co, m};
  endfunction

  task automatic run_op(input logic [15:0] ta,
                        input logic [15:0] tb_,
                        input logic tc,
                        input logic ts,
                        input int stall);
    logic [17:0] e;
    logic [15:0] hs;
    logic        hc;
    int cyc;
    e = ref_add(16, ta, tb_, tc, ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub_i = ts;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub_i = 1'($urandom);
    check("busy_run", 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, 8);
    check("sum", 32'(sum), 32'(e[15:0]));
    check("cout", 32'(cout), 32'(e[16]));
    check("ovf", 32'(ovf), 32'(e[17]));
    check("rdy_done", 32'(in_ready), 32'd0);
    hs = sum;
    hc = cout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(hs));
      check("hold_cout", 32'(cout), 32'(hc));
      check("hold_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("rdy_back", 32'(in_ready), 32'd1);
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int C = 1 << gi;
    localparam int N = 8 / C;
    logic       iv, ir, ov, co, vf, bz, ci;
    logic [7:0] x, y, s;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(C)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (x),
      .b         (y),
      .cin       (ci),
`ifdef SEQ_ADDER_SUB_EN
      .sub       (1'b0),
`endif
      .out_valid (ov),
      .out_ready (1'b1),
      .sum       (s),
      .cout      (co),
      .ovf       (vf),
      .busy      (bz)
    );

    initial begin
      iv = 1'b0; x = '0; y = '0; ci = 1'b0;
      wait (sweep_go);
      for (int n = 0; n < 8; n++) begin
        logic [17:0] e;
        int cyc;
        @(negedge clk);
        x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
        e = ref_add(8, {8'd0, x}, {8'd0, y}, ci, 1'b0);
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        cyc = 0;
        while (!ov && cyc < 20) begin
          @(posedge clk); #1;
          cyc++;
        end
        check($sformatf("sw%0d_lat", C), cyc, N);
        check($sformatf("sw%0d_sum", C), 32'(s), 32'(e[7:0]));
        check($sformatf("sw%0d_cout", C), 32'(co), 32'(e[16]));
        check($sformatf("sw%0d_ovf", C), 32'(vf), 32'(e[17]));
        @(posedge clk); #1;
      end
      sweep_done++;
    end
  end

  initial begin
    int cyc;
    n_cmp = 0; n_bad = 0;
    sweep_go = 1'b0; sweep_done = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 5);

    // Abort an operation while chunk 3 is in flight.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef SEQ_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic sb;
`ifdef SEQ_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run_op(16'($urandom), 16'($urandom), 1'($urandom), sb,
             int'($urandom_range(0, 2)));
    end

    sweep_go = 1'b1;
    cyc = 0;
    while (sweep_done < 4 && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    check("sweep_finish", sweep_done, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
